// File: rtl/huffman_bit_packer.sv
// Huffman bit packer: captures a 10-entry code table on Load, then packs
// symbol codewords MSB-first into 16-bit words with flush and zero padding.
// Ports: Clk_in, Rst (async, high), Load, Code0..Code9 {len[3:0], cw[8:0]},
//   Sym_valid/Sym_ready/Sym_in, Flush, Word_valid/Word_ready/Word_out,
//   Word_last, Word_nbits, Flush_done, Err (sticky illegal symbol).
// Option: define HUFF_PACK_BITCNT_EN to add the Total_bits counter output.
module huffman_bit_packer #(
    parameter int NUM_SYM = 10,
    parameter int LEN_W   = 4,
    parameter int CW_W    = 9,
    parameter int OUT_W   = 16
) (
    input  logic                   Clk_in,
    input  logic                   Rst,
    input  logic                   Load,
    input  logic [LEN_W+CW_W-1:0]  Code0,
    input  logic [LEN_W+CW_W-1:0]  Code1,
    input  logic [LEN_W+CW_W-1:0]  Code2,
    input  logic [LEN_W+CW_W-1:0]  Code3,
    input  logic [LEN_W+CW_W-1:0]  Code4,
    input  logic [LEN_W+CW_W-1:0]  Code5,
    input  logic [LEN_W+CW_W-1:0]  Code6,
    input  logic [LEN_W+CW_W-1:0]  Code7,
    input  logic [LEN_W+CW_W-1:0]  Code8,
    input  logic [LEN_W+CW_W-1:0]  Code9,
    input  logic                   Sym_valid,
    output logic                   Sym_ready,
    input  logic [3:0]             Sym_in,
    input  logic                   Flush,
    output logic                   Word_valid,
    input  logic                   Word_ready,
    output logic [OUT_W-1:0]       Word_out,
    output logic                   Word_last,
    output logic [4:0]             Word_nbits,
    output logic                   Flush_done,
    output logic                   Err
`ifdef HUFF_PACK_BITCNT_EN
    ,
    output logic [31:0]            Total_bits
`endif
);

    localparam int CODE_W = LEN_W + CW_W;

    typedef enum logic [2:0] {NOTAB, RUN, DRAIN, LASTW, DONE} state_t;

    state_t            state_q, state_d;
    logic [CODE_W-1:0] tab_q [NUM_SYM];
    logic [31:0]       acc_q, acc_d, acc_b, bits;
    logic [5:0]        cnt_q, cnt_d, cnt_b;
    logic [6:0]        sh;
    logic [CODE_W-1:0] entry;
    logic [LEN_W-1:0]  len;
    logic [CW_W-1:0]   cw;
    logic              legal, accept, out_free, emit, pad;
    logic [OUT_W-1:0]  word_d;
    logic [4:0]        nbits_d;
    logic              valid_d, last_d, err_d;

    always_comb begin
        entry = '0;
        for (int i = 0; i < NUM_SYM; i++) begin
            if (Sym_in == 4'(i)) entry = tab_q[i];
        end
    end

    assign len       = entry[CODE_W-1:CW_W];
    assign cw        = entry[CW_W-1:0];
    assign legal     = (int'(Sym_in) < NUM_SYM) && (len != '0);
    assign Sym_ready = (state_q == RUN) && (cnt_q < 6'd16);
    assign accept    = Sym_valid && Sym_ready;
    assign out_free  = !Word_valid || Word_ready;
    assign emit      = (cnt_q >= 6'd16) && out_free;
    assign pad       = (state_q == DRAIN) && (cnt_q < 6'd16)
                       && out_free && (cnt_q != 6'd0);
    assign Flush_done = (state_q == DONE);

    // Emit and accept share the pre-edge buffer: shift first, then append
    // the masked codeword directly below the surviving bits.
    always_comb begin
        acc_b   = emit ? {acc_q[15:0], 16'h0000} : acc_q;
        cnt_b   = emit ? (cnt_q - 6'd16) : cnt_q;
        bits    = 32'(cw) & ((32'd1 << len) - 32'd1);
        sh      = 7'd32 - {1'b0, cnt_b} - {3'b000, len};
        acc_d   = acc_b;
        cnt_d   = cnt_b;
        word_d  = Word_out;
        nbits_d = Word_nbits;
        last_d  = Word_last;
        valid_d = Word_valid && !Word_ready;
        err_d   = Err || (accept && !legal);
        if (accept && legal) begin
            acc_d = acc_b | (bits << sh);
            cnt_d = cnt_b + {2'b00, len};
        end
        if (emit) begin
            word_d  = acc_q[31:16];
            nbits_d = 5'd16;
            last_d  = 1'b0;
            valid_d = 1'b1;
        end else if (pad) begin
            // Bits below cnt are always zero, so this is the padded word.
            word_d  = acc_q[31:16];
            nbits_d = cnt_q[4:0];
            last_d  = 1'b1;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NOTAB: if (Load) state_d = RUN;
            RUN:   if (Flush) state_d = DRAIN;
            DRAIN: begin
                if ((cnt_q < 6'd16) && out_free)
                    state_d = (cnt_q != 6'd0) ? LASTW : DONE;
            end
            LASTW: if (Word_valid && Word_ready) state_d = DONE;
            DONE:  state_d = RUN;
            default: state_d = NOTAB;
        endcase
    end

    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) begin
            state_q    <= NOTAB;
            acc_q      <= '0;
            cnt_q      <= '0;
            Word_out   <= '0;
            Word_nbits <= '0;
            Word_last  <= 1'b0;
            Word_valid <= 1'b0;
            Err        <= 1'b0;
            for (int i = 0; i < NUM_SYM; i++) tab_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            Word_out   <= word_d;
            Word_nbits <= nbits_d;
            Word_last  <= last_d;
            Word_valid <= valid_d;
            Err        <= err_d;
            if (Load) begin
                tab_q[0] <= Code0;
                tab_q[1] <= Code1;
                tab_q[2] <= Code2;
                tab_q[3] <= Code3;
                tab_q[4] <= Code4;
                tab_q[5] <= Code5;
                tab_q[6] <= Code6;
                tab_q[7] <= Code7;
                tab_q[8] <= Code8;
                tab_q[9] <= Code9;
            end
        end
    end

`ifdef HUFF_PACK_BITCNT_EN
    // Counts only appended codeword bits; padding is excluded.
    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) Total_bits <= '0;
        else if (accept && legal) Total_bits <= Total_bits + 32'(len);
    end
`endif

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Testbench for huffman_bit_packer: directed symbol streams with a
// word scoreboard checked by an independent output monitor.
module tb_huffman_bit_packer;

    logic        Clk_in = 1'b0;
    logic        Rst = 1'b1;
    logic        Load = 1'b0;
    logic [12:0] code [10];
    logic        Sym_valid = 1'b0;
    logic        Sym_ready;
    logic [3:0]  Sym_in = 4'd0;
    logic        Flush = 1'b0;
    logic        Word_valid;
    logic        Word_ready = 1'b1;
    logic [15:0] Word_out;
    logic        Word_last;
    logic [4:0]  Word_nbits;
    logic        Flush_done;
    logic        Err;
`ifdef HUFF_PACK_BITCNT_EN
    logic [31:0] Total_bits;
`endif

    huffman_bit_packer dut (
        .Clk_in(Clk_in), .Rst(Rst), .Load(Load),
        .Code0(code[0]), .Code1(code[1]), .Code2(code[2]),
        .Code3(code[3]), .Code4(code[4]), .Code5(code[5]),
        .Code6(code[6]), .Code7(code[7]), .Code8(code[8]),
        .Code9(code[9]),
        .Sym_valid(Sym_valid), .Sym_ready(Sym_ready), .Sym_in(Sym_in),
        .Flush(Flush), .Word_valid(Word_valid), .Word_ready(Word_ready),
        .Word_out(Word_out), .Word_last(Word_last),
        .Word_nbits(Word_nbits), .Flush_done(Flush_done), .Err(Err)
`ifdef HUFF_PACK_BITCNT_EN
        , .Total_bits(Total_bits)
`endif
    );

    always #5 Clk_in = ~Clk_in;

    typedef struct packed {
        logic [15:0] w;
        logic [4:0]  n;
        logic        l;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    logic        stall_q = 1'b0;
    logic [15:0] w_q;
    logic [4:0]  n_q;
    logic        l_q;

    // Monitor: pops the scoreboard on each word handshake and checks that
    // a stalled word holds steady.
    always @(negedge Clk_in) begin
        exp_t e;
        if (Rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                tests++;
                if (!Word_valid || Word_out !== w_q || Word_nbits !== n_q
                    || Word_last !== l_q) begin
                    fails++;
                    $display("FAIL hold: got v=%b %h/%0d/%b want %h/%0d/%b",
                             Word_valid, Word_out, Word_nbits, Word_last,
                             w_q, n_q, l_q);
                end
            end
            if (Word_valid && Word_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL word_unexpected: got %h/%0d/%b, want none",
                             Word_out, Word_nbits, Word_last);
                end else begin
                    e = q.pop_front();
                    if (Word_out !== e.w || Word_nbits !== e.n
                        || Word_last !== e.l) begin
                        fails++;
                        $display("FAIL word: got %h/%0d/%b want %h/%0d/%b",
                                 Word_out, Word_nbits, Word_last,
                                 e.w, e.n, e.l);
                    end
                end
            end
            stall_q = Word_valid && !Word_ready;
            w_q = Word_out;
            n_q = Word_nbits;
            l_q = Word_last;
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic sync();
        @(posedge Clk_in);
        #1;
    endtask

    task automatic push(input logic [15:0] w, input logic [4:0] n,
                        input logic l);
        q.push_back({w, n, l});
    endtask

    task automatic load_tab();
        sync();
        code[0] = 13'h0402;
        code[1] = 13'h0603;
        code[2] = 13'h13FF;
        for (int i = 3; i < 10; i++) code[i] = 13'h0000;
        Load = 1'b1;
        sync();
        Load = 1'b0;
    endtask

    task automatic send(input logic [3:0] s);
        int n;
        sync();
        Sym_in = s;
        Sym_valid = 1'b1;
        n = 0;
        @(negedge Clk_in);
        while (!Sym_ready && n < 200) begin
            n++;
            @(negedge Clk_in);
        end
        if (!Sym_ready) check("sym_ready_timeout", 32'(Sym_ready), 32'd1);
        sync();
        Sym_valid = 1'b0;
    endtask

    task automatic flush();
        sync();
        Flush = 1'b1;
        sync();
        Flush = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge Clk_in);
        while (!Flush_done && n < 100) begin
            n++;
            @(negedge Clk_in);
        end
        check("flush_done", 32'(Flush_done), 32'd1);
        @(negedge Clk_in);
        check("flush_done_width", 32'(Flush_done), 32'd0);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        @(negedge Clk_in);
        while ((q.size() != 0 || Word_valid) && n < 200) begin
            n++;
            @(negedge Clk_in);
        end
        check("words_left", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        for (int i = 0; i < 10; i++) code[i] = 13'h0000;
        repeat (2) @(negedge Clk_in);
        check("rst_valid", 32'(Word_valid), 32'd0);
        check("rst_word", 32'(Word_out), 32'd0);
        check("rst_nbits", 32'(Word_nbits), 32'd0);
        check("rst_last", 32'(Word_last), 32'd0);
        check("rst_done", 32'(Flush_done), 32'd0);
        check("rst_err", 32'(Err), 32'd0);
        check("rst_ready", 32'(Sym_ready), 32'd0);
        sync();
        Rst = 1'b0;
        repeat (2) @(negedge Clk_in);
        check("notab_ready", 32'(Sym_ready), 32'd0);

        // Eight 2-bit "10" codes fill exactly one word.
        load_tab();
        push(16'hAAAA, 5'd16, 1'b0);
        for (int i = 0; i < 8; i++) send(4'd0);
        wait_empty();
        check("s1_err", 32'(Err), 32'd0);
`ifdef HUFF_PACK_BITCNT_EN
        check("total_bits", Total_bits, 32'd16);
`endif

        // Fifteen bits of "011" repeated, padded with one zero.
        push(16'h6DB6, 5'd15, 1'b1);
        for (int i = 0; i < 5; i++) send(4'd1);
        flush();
        wait_done();
        check("s2_left", 32'(q.size()), 32'd0);

        // Eighteen ones: a full word then a 2-bit tail.
        push(16'hFFFF, 5'd16, 1'b0);
        push(16'hC000, 5'd2, 1'b1);
        send(4'd2);
        send(4'd2);
        flush();
        wait_done();
        check("s3_left", 32'(q.size()), 32'd0);

        // Backpressure: the held word blocks the second word in the buffer.
        push(16'hAAAA, 5'd16, 1'b0);
        push(16'hAAAA, 5'd16, 1'b0);
        sync();
        Word_ready = 1'b0;
        Sym_in = 4'd0;
        Sym_valid = 1'b1;
        acc = 0;
        repeat (40) begin
            @(negedge Clk_in);
            if (Sym_valid && Sym_ready) acc++;
        end
        sync();
        Sym_valid = 1'b0;
        check("bp_accepts", 32'(acc), 32'd16);
        check("bp_ready", 32'(Sym_ready), 32'd0);
        check("bp_valid", 32'(Word_valid), 32'd1);
        check("bp_word", 32'(Word_out), 32'h0000AAAA);
        Word_ready = 1'b1;
        wait_empty();

        // Illegal symbols: out-of-range index and zero-length entry.
        send(4'd12);
        check("err_idx", 32'(Err), 32'd1);
        send(4'd3);
        check("err_len0", 32'(Err), 32'd1);
        flush();
        wait_done();
        check("err_sticky", 32'(Err), 32'd1);
        check("err_nowords", 32'(q.size()), 32'd0);

        // Reset with 7 bits buffered discards them.
        send(4'd1);
        send(4'd0);
        send(4'd0);
        sync();
        Rst = 1'b1;
        Sym_in = 4'd0;
        Sym_valid = 1'b1;
        @(negedge Clk_in);
        check("mid_valid", 32'(Word_valid), 32'd0);
        check("mid_word", 32'(Word_out), 32'd0);
        check("mid_nbits", 32'(Word_nbits), 32'd0);
        check("mid_last", 32'(Word_last), 32'd0);
        check("mid_err", 32'(Err), 32'd0);
        check("mid_ready", 32'(Sym_ready), 32'd0);
        sync();
        Rst = 1'b0;
        repeat (3) @(negedge Clk_in);
        check("mid_notab_ready", 32'(Sym_ready), 32'd0);
        check("mid_no_word", 32'(Word_valid), 32'd0);
        sync();
        Sym_valid = 1'b0;
        load_tab();
        push(16'hAAAA, 5'd16, 1'b0);
        for (int i = 0; i < 8; i++) send(4'd0);
        wait_empty();
        check("post_rst_err", 32'(Err), 32'd0);

        repeat (3) @(negedge Clk_in);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/huffman_bit_packer.md
Name: huffman_bit_packer

Overview:
- Downstream of the Huffman code-table generator.
- Captures the ten 13-bit code-table entries when the generator signals completion, then converts a stream of 4-bit symbol indices into MSB-first packed 16-bit output words.
- Supports valid/ready backpressure on both sides and a flush operation that zero-pads the final partial word.

Parameters:
- NUM_SYM, 10, number of table entries and legal symbol indices (0..NUM_SYM-1).
- LEN_W, 4, codeword-length field width: Code[12:9].
- CW_W, 9, codeword field width: Code[8:0], right-aligned.
- OUT_W, 16, packed output word width.

Ports:
- Clk_in  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Load  in  1  table-capture strobe; connect to the generator's Fin.
- Code0..Code9  in  13 each  table entries {len[3:0], codeword[8:0]}.
- Sym_valid  in  1  symbol present.
- Sym_ready  out  1  symbol accepted this cycle when high together with Sym_valid.
- Sym_in  in  4  symbol index.
- Flush  in  1  one-cycle request to drain and pad.
- Word_valid  out  1  output word present.
- Word_ready  in  1  downstream accepts the word.
- Word_out  out  16  packed bits; first code bit in bit 15.
- Word_last  out  1  high on the flush-generated final word.
- Word_nbits  out  5  meaningful bits in Word_out: 16, or 1..15 on the final partial word.
- Flush_done  out  1  one-cycle pulse when the flush completes.
- Err  out  1  sticky illegal-symbol flag; cleared only by reset.

Behaviour:
- Reset values: all outputs 0; accumulator, count and table cleared; state NOTAB.
- Reset is honoured mid-operation: buffered bits and pending words are discarded.
- Table capture:
  - Load high at a clock edge latches all of Code0..Code9 in one cycle and moves NOTAB to RUN.
  - Load in any other state overwrites the table; the new table applies only to symbols accepted afterwards.
- Accumulator: 32-bit buffer, MSB-aligned, with a 6-bit count cnt (0..31).
- Sym_ready = (state==RUN) && (cnt < 16).
- Symbol accept:
  - Append the codeword's low len bits, MSB first, below the existing bits.
  - cnt += len.
  - Maximum cnt is 15+9 = 24, so the buffer never overflows.
- Illegal symbol (Sym_in >= NUM_SYM, or table len == 0):
  - Handshake completes.
  - No bits are appended.
  - Err is set to 1.
- Word emit:
  - Condition: cnt >= 16 and (Word_valid==0 or Word_ready==1).
  - The top 16 bits load into Word_out; Word_valid=1; Word_nbits=16; Word_last=0.
  - The buffer shifts left 16; cnt -= 16.
- Same-cycle emit and accept: both use the pre-edge state. New cnt = cnt - 16 + len.
- Word_out, Word_nbits and Word_last stay stable while Word_valid && !Word_ready.
- Word_valid drops after a handshake unless a new word loads in the same edge.
- Latency: a symbol accepted at edge k that completes a word gives Word_valid high after edge k+1 when the output register is free.
- States:
  - NOTAB: Sym_ready=0; Flush ignored.
  - RUN: Flush -> DRAIN. A symbol presented in the Flush cycle is still accepted.
  - DRAIN: Sym_ready=0; full words continue to emit.
    - When cnt < 16 and the output register is free: if cnt > 0, load the padded word with Word_nbits=cnt and Word_last=1, clear cnt, go to LASTW; if cnt == 0, go to DONE.
  - LASTW: wait for the handshake of the Word_last word -> DONE.
  - DONE: Flush_done=1 for exactly one cycle -> RUN.
- Flush received while not in RUN is ignored.

Optional Feature:
- Macro: HUFF_PACK_BITCNT_EN.
- Defined:
  - Adds output port Total_bits, 32 bits, reset 0.
  - Total_bits increments by len on every legal symbol accept and wraps modulo 2^32.
  - Padding bits are not counted.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Table used: Code0=13'h0402 (len 2, 10), Code1=13'h0603 (len 3, 011), Code2=13'h13FF (len 9, 1FF), Code3..Code9=13'h0000. Word_ready=1 unless stated.
- Load the table, send Sym 0 eight times -> one word 16'hAAAA, Word_nbits=16, Word_last=0, no Err.
- Send Sym 1 five times, then Flush -> one word 16'h6DB6, Word_nbits=15, Word_last=1, then Flush_done pulses for 1 cycle.
- Send Sym 2 twice, then Flush -> words 16'hFFFF (nbits 16, last 0), then 16'hC000 (nbits 2, last 1), then Flush_done.
- Word_ready=0 and a continuous stream of Sym 0 -> first word 16'hAAAA held stable, Sym_ready drops after 16 accepts. Raising Word_ready resumes the stream: second 16'hAAAA, no bits lost or duplicated.
- Send Sym_in=12, then Sym_in=3 -> both handshakes complete, no word, Err=1 and stays 1. Flush with cnt=0 -> no word, Flush_done pulse.
- Assert Rst mid-stream with 7 bits buffered -> all outputs 0, state NOTAB, Sym_ready=0 until Load. With HUFF_PACK_BITCNT_EN defined, Total_bits reads 16 after scenario 1.
